// File: rtl/wb_pkg.sv
// Shared WISHBONE definitions: default bus widths and the arbiter grant encoding.
package wb_pkg;

  localparam int WB_AW = 16;
  localparam int WB_DW = 16;

  typedef enum logic [1:0] {
    GRANT_IDLE = 2'd0,
    GRANT_M0   = 2'd1,
    GRANT_M1   = 2'd2
  } grant_t;

endpackage

// File: rtl/wb_arb_select.sv
// Combinational winner selection between FETCH (bit 0) and MEMORY (bit 1) requests.
module wb_arb_select
  import wb_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic [1:0] req,
  input  logic       last,
  output grant_t     winner
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    winner = GRANT_IDLE;
    case (req)
      2'b01: winner = GRANT_M0;
      2'b10: winner = GRANT_M1;
      2'b11: begin
        // On contention round-robin favours whoever did not win last time.
        if (ROUND_ROBIN) winner = last ? GRANT_M0 : GRANT_M1;
        else             winner = GRANT_M1;
      end
      default: winner = GRANT_IDLE;
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master pipelined WISHBONE arbiter: FETCH (read-only) and MEMORY share one slave,
// grant held for a whole bus cycle, slave responses routed only to the granted master.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int AW          = WB_AW,
  parameter int DW          = WB_DW,
  parameter int LGDEPTH     = 4,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            m0_wb_cyc_i,
  input  logic            m0_wb_stb_i,
  input  logic [AW-1:0]   m0_wb_addr_i,
  output logic            m0_wb_stall_o,
  output logic            m0_wb_ack_o,
  output logic [DW-1:0]   m0_wb_data_o,
  input  logic            m1_wb_cyc_i,
  input  logic            m1_wb_stb_i,
  input  logic            m1_wb_we_i,
  input  logic [AW-1:0]   m1_wb_addr_i,
  input  logic [DW-1:0]   m1_wb_data_i,
  input  logic [DW/8-1:0] m1_wb_sel_i,
  output logic            m1_wb_stall_o,
  output logic            m1_wb_ack_o,
  output logic [DW-1:0]   m1_wb_data_o,
  output logic            s_wb_cyc_o,
  output logic            s_wb_stb_o,
  output logic            s_wb_we_o,
  output logic [AW-1:0]   s_wb_addr_o,
  output logic [DW-1:0]   s_wb_data_o,
  output logic [DW/8-1:0] s_wb_sel_o,
  input  logic            s_wb_stall_i,
  input  logic            s_wb_ack_i,
  input  logic [DW-1:0]   s_wb_data_i
);

  grant_t               grant_r;
  grant_t               winner;
  logic                 last_r;
  logic [LGDEPTH-1:0]   cnt_r;
  logic                 granted_cyc;
  logic                 arb_open;
  logic                 ack_fwd;
  logic                 req_issued;

  wb_arb_select #(.ROUND_ROBIN(ROUND_ROBIN)) u_select (
    .req    ({m1_wb_cyc_i, m0_wb_cyc_i}),
    .last   (last_r),
    .winner (winner)
  );

  always_comb begin
    granted_cyc = 1'b0;
    case (grant_r)
      GRANT_M0: granted_cyc = m0_wb_cyc_i;
      GRANT_M1: granted_cyc = m1_wb_cyc_i;
      default:  granted_cyc = 1'b0;
    endcase
  end

  // Re-arbitrate only when the bus is free; a master holding cyc is never preempted.
  assign arb_open   = (grant_r == GRANT_IDLE) || !granted_cyc;
  assign ack_fwd    = s_wb_ack_i && (cnt_r != '0);
  assign req_issued = s_wb_stb_o && !s_wb_stall_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      grant_r <= GRANT_IDLE;
      last_r  <= 1'b1;
      cnt_r   <= '0;
    end else if (arb_open) begin
      grant_r <= winner;
      cnt_r   <= '0;
      if (winner == GRANT_M0) last_r <= 1'b0;
      if (winner == GRANT_M1) last_r <= 1'b1;
    end else begin
      case ({req_issued, ack_fwd})
        2'b10:   cnt_r <= cnt_r + LGDEPTH'(1);
        2'b01:   cnt_r <= cnt_r - LGDEPTH'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  always_comb begin
    s_wb_cyc_o    = 1'b0;
    s_wb_stb_o    = 1'b0;
    s_wb_we_o     = 1'b0;
    s_wb_addr_o   = '0;
    s_wb_data_o   = '0;
    s_wb_sel_o    = '0;
    m0_wb_stall_o = 1'b1;
    m0_wb_ack_o   = 1'b0;
    m1_wb_stall_o = 1'b1;
    m1_wb_ack_o   = 1'b0;
    case (grant_r)
      GRANT_M0: begin
        s_wb_cyc_o    = m0_wb_cyc_i;
        s_wb_stb_o    = m0_wb_stb_i;
        s_wb_addr_o   = m0_wb_addr_i;
        m0_wb_stall_o = s_wb_stall_i;
        m0_wb_ack_o   = ack_fwd;
      end
      GRANT_M1: begin
        s_wb_cyc_o    = m1_wb_cyc_i;
        s_wb_stb_o    = m1_wb_stb_i;
        s_wb_we_o     = m1_wb_we_i;
        s_wb_addr_o   = m1_wb_addr_i;
        s_wb_data_o   = m1_wb_data_i;
        s_wb_sel_o    = m1_wb_sel_i;
        m1_wb_stall_o = s_wb_stall_i;
        m1_wb_ack_o   = ack_fwd;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; only the ack qualifies it.
  assign m0_wb_data_o = s_wb_data_i;
  assign m1_wb_data_o = s_wb_data_i;

`ifdef FORMAL
  always_ff @(posedge clk_i) begin
    if (rstn_i) assert (cnt_r != {LGDEPTH{1'b1}});
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: round-robin and fixed-priority instances share stimulus; a
// scoreboard monitor checks every forwarded ack, directed checks cover bus routing.
module tb_wb_arbiter;
  import wb_pkg::*;

  typedef struct {
    logic        master;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        m0_cyc = 0, m0_stb = 0;
  logic [15:0] m0_addr = '0;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [15:0] m1_addr = '0, m1_wdata = '0;
  logic [1:0]  m1_sel = '0;
  logic        s_stall = 0, s_ack = 0;
  logic [15:0] s_rdata = '0;

  // Index 0 = round-robin instance, index 1 = fixed-priority instance.
  logic [1:0]  m0_stall, m0_ack, m1_stall, m1_ack;
  logic [1:0]  s_cyc, s_stb, s_we;
  logic [15:0] m0_rdata [2];
  logic [15:0] m1_rdata [2];
  logic [15:0] s_addr [2];
  logic [15:0] s_wdata [2];
  logic [1:0]  s_sel [2];

  exp_t q_rr[$];
  exp_t q_fp[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.AW(16), .DW(16), .LGDEPTH(4), .ROUND_ROBIN(1'b1)) u_rr (
    .clk_i(clk), .rstn_i(rstn),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_addr_i(m0_addr),
    .m0_wb_stall_o(m0_stall[0]), .m0_wb_ack_o(m0_ack[0]), .m0_wb_data_o(m0_rdata[0]),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we), .m1_wb_addr_i(m1_addr),
    .m1_wb_data_i(m1_wdata), .m1_wb_sel_i(m1_sel),
    .m1_wb_stall_o(m1_stall[0]), .m1_wb_ack_o(m1_ack[0]), .m1_wb_data_o(m1_rdata[0]),
    .s_wb_cyc_o(s_cyc[0]), .s_wb_stb_o(s_stb[0]), .s_wb_we_o(s_we[0]), .s_wb_addr_o(s_addr[0]),
    .s_wb_data_o(s_wdata[0]), .s_wb_sel_o(s_sel[0]),
    .s_wb_stall_i(s_stall), .s_wb_ack_i(s_ack), .s_wb_data_i(s_rdata)
  );

  wb_arbiter #(.AW(16), .DW(16), .LGDEPTH(4), .ROUND_ROBIN(1'b0)) u_fp (
    .clk_i(clk), .rstn_i(rstn),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_addr_i(m0_addr),
    .m0_wb_stall_o(m0_stall[1]), .m0_wb_ack_o(m0_ack[1]), .m0_wb_data_o(m0_rdata[1]),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we), .m1_wb_addr_i(m1_addr),
    .m1_wb_data_i(m1_wdata), .m1_wb_sel_i(m1_sel),
    .m1_wb_stall_o(m1_stall[1]), .m1_wb_ack_o(m1_ack[1]), .m1_wb_data_o(m1_rdata[1]),
    .s_wb_cyc_o(s_cyc[1]), .s_wb_stb_o(s_stb[1]), .s_wb_we_o(s_we[1]), .s_wb_addr_o(s_addr[1]),
    .s_wb_data_o(s_wdata[1]), .s_wb_sel_o(s_sel[1]),
    .s_wb_stall_i(s_stall), .s_wb_ack_i(s_ack), .s_wb_data_i(s_rdata)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s[%0d].s_cyc", tag, d), 32'(s_cyc[d]), 32'd0);
      check($sformatf("%s[%0d].s_stb", tag, d), 32'(s_stb[d]), 32'd0);
      check($sformatf("%s[%0d].m0_stall", tag, d), 32'(m0_stall[d]), 32'd1);
      check($sformatf("%s[%0d].m1_stall", tag, d), 32'(m1_stall[d]), 32'd1);
    end
  endtask

  task automatic push_both(input logic master, input logic [15:0] data);
    exp_t e;
    e.master = master;
    e.data   = data;
    q_rr.push_back(e);
    q_fp.push_back(e);
  endtask

  // Scoreboard monitor: every ack presented by either instance must match the queue head.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (m0_ack[d] || m1_ack[d]) begin
        exp_t e;
        logic have;
        have = (d == 0) ? (q_rr.size() != 0) : (q_fp.size() != 0);
        if (!have || (m0_ack[d] && m1_ack[d])) begin
          check($sformatf("unexpected_ack[%0d]", d), 32'({m1_ack[d], m0_ack[d]}), 32'd0);
        end else begin
          if (d == 0) e = q_rr.pop_front();
          else        e = q_fp.pop_front();
          check($sformatf("ack_master[%0d]", d), 32'(m1_ack[d]), 32'(e.master));
          check($sformatf("ack_data[%0d]", d),
                32'(m1_ack[d] ? m1_rdata[d] : m0_rdata[d]), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #3;
    chk_idle("reset");
    tick();
    tick();
    rstn = 1'b1;

    // Single m0 read
    tick();
    m0_cyc = 1; m0_stb = 1; m0_addr = 16'h0010;
    tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("m0rd[%0d].s_cyc", d), 32'(s_cyc[d]), 32'd1);
      check($sformatf("m0rd[%0d].s_stb", d), 32'(s_stb[d]), 32'd1);
      check($sformatf("m0rd[%0d].s_addr", d), 32'(s_addr[d]), 32'h0010);
      check($sformatf("m0rd[%0d].s_we", d), 32'(s_we[d]), 32'd0);
      check($sformatf("m0rd[%0d].m0_stall", d), 32'(m0_stall[d]), 32'd0);
      check($sformatf("m0rd[%0d].m1_stall", d), 32'(m1_stall[d]), 32'd1);
    end
    tick();
    m0_stb = 0; s_ack = 1; s_rdata = 16'h1234;
    push_both(1'b0, 16'h1234);
    tick();
    s_ack = 0; m0_cyc = 0;
    tick();
    chk_idle("m0rd_end");

    // Contention straight after reset
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    m0_cyc = 1; m0_stb = 0; m0_addr = 16'h0044;
    m1_cyc = 1; m1_stb = 0;
    tick();
    check("cont_rr.m0_stall", 32'(m0_stall[0]), 32'd0);
    check("cont_rr.m1_stall", 32'(m1_stall[0]), 32'd1);
    check("cont_rr.s_addr", 32'(s_addr[0]), 32'h0044);
    check("cont_fp.m0_stall", 32'(m0_stall[1]), 32'd1);
    check("cont_fp.m1_stall", 32'(m1_stall[1]), 32'd0);
    m1_we = 1; m1_addr = 16'h0200; m1_wdata = 16'hBEEF; m1_sel = 2'b11; m1_stb = 1;
    #1;
    check("wr_fp.s_stb", 32'(s_stb[1]), 32'd1);
    check("wr_fp.s_we", 32'(s_we[1]), 32'd1);
    check("wr_fp.s_addr", 32'(s_addr[1]), 32'h0200);
    check("wr_fp.s_data", 32'(s_wdata[1]), 32'hBEEF);
    check("wr_fp.s_sel", 32'(s_sel[1]), 32'h3);
    check("wr_rr.s_stb", 32'(s_stb[0]), 32'd0);
    check("wr_rr.s_we", 32'(s_we[0]), 32'd0);
    check("wr_rr.s_data", 32'(s_wdata[0]), 32'h0);
    check("wr_rr.s_sel", 32'(s_sel[0]), 32'h0);
    tick();
    // The round-robin instance has nothing outstanding, so this ack must be dropped there.
    m1_stb = 0; s_ack = 1; s_rdata = 16'h5A5A;
    q_fp.push_back('{master: 1'b1, data: 16'h5A5A});
    tick();
    s_ack = 0; m0_cyc = 0;
    tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("handover[%0d].s_cyc", d), 32'(s_cyc[d]), 32'd1);
      check($sformatf("handover[%0d].m1_stall", d), 32'(m1_stall[d]), 32'd0);
      check($sformatf("handover[%0d].m0_stall", d), 32'(m0_stall[d]), 32'd1);
      check($sformatf("handover[%0d].s_addr", d), 32'(s_addr[d]), 32'h0200);
      check($sformatf("handover[%0d].s_we", d), 32'(s_we[d]), 32'd1);
    end
    m1_cyc = 0;
    tick();
    chk_idle("cont_end");

    // Three pipelined m1 reads behind a two-cycle slave stall
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_addr = 16'h0300;
    tick();
    s_stall = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      for (int d = 0; d < 2; d++) begin
        check($sformatf("stall%0d[%0d].m1_stall", k, d), 32'(m1_stall[d]), 32'd1);
        check($sformatf("stall%0d[%0d].s_stb", k, d), 32'(s_stb[d]), 32'd1);
        check($sformatf("stall%0d[%0d].s_addr", k, d), 32'(s_addr[d]), 32'h0300);
      end
      tick();
    end
    s_stall = 0;
    tick();
    m1_addr = 16'h0301;
    tick();
    m1_addr = 16'h0302;
    tick();
    m1_stb = 0;
    // Fourth ack has no matching request and must not reach either master.
    for (int i = 0; i < 4; i++) begin
      s_ack = 1; s_rdata = 16'hA000 + 16'(i);
      if (i < 3) push_both(1'b1, 16'hA000 + 16'(i));
      tick();
    end
    s_ack = 0; m1_cyc = 0;
    tick();
    chk_idle("burst_end");

    // Stray ack while idle
    s_ack = 1; s_rdata = 16'hDEAD;
    #1;
    for (int d = 0; d < 2; d++)
      check($sformatf("idle_ack[%0d]", d), 32'({m1_ack[d], m0_ack[d]}), 32'd0);
    tick();
    s_ack = 0;

    // Reset in the middle of an m0 transfer
    m0_cyc = 1; m0_stb = 1; m0_addr = 16'h0055;
    tick();
    for (int d = 0; d < 2; d++)
      check($sformatf("pre_rst[%0d].s_cyc", d), 32'(s_cyc[d]), 32'd1);
    tick();
    m0_stb = 0;
    #2;
    rstn = 1'b0;
    #1;
    s_ack = 1; s_rdata = 16'h7777;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("mid_rst[%0d].s_cyc", d), 32'(s_cyc[d]), 32'd0);
      check($sformatf("mid_rst[%0d].m0_stall", d), 32'(m0_stall[d]), 32'd1);
      check($sformatf("mid_rst[%0d].m0_ack", d), 32'(m0_ack[d]), 32'd0);
    end
    m0_cyc = 0;
    tick();
    s_ack = 0; rstn = 1'b1;
    tick();
    chk_idle("post_rst");

    tick();
    check("rr_pending", 32'(q_rr.size()), 32'd0);
    check("fp_pending", 32'(q_fp.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
